// File: rtl/impact_access_sequencer.sv
// Byte-level SRAM access sequencer for the IMPACT head: accepts one request, walks it
// through setup, enable-pulse and hold phases, then returns a response.
// Optional build macro IMPACT_ACCESS_CNT_EN adds saturating write/read access counters.
module impact_access_sequencer #(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int HOLD_CYC  = 1,
   parameter int CNT_W     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_bank,
   input  logic [9:0]  req_word,
   input  logic [1:0]  req_byte,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_we,
   output logic        busy,
   output logic [7:0]  sram_data_in,
   output logic [9:0]  sram_word_sel,
   output logic [1:0]  sram_bank_sel,
   output logic [1:0]  sram_byte_sel,
   output logic        sram_we,
   output logic        sram_re,
`ifdef IMPACT_ACCESS_CNT_EN
   output logic [15:0] wr_count,
   output logic [15:0] rd_count,
`endif
   input  logic [7:0]  sram_data_out
);

   // A zero-length phase would never terminate, so every phase lasts at least one cycle.
   localparam int SETUP_EFF = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
   localparam int PULSE_EFF = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
   localparam int HOLD_EFF  = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_EFF - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_EFF - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_EFF - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_PULSE = 3'd2,
      S_HOLD  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CNT_W-1:0]  w_last;
   logic              w_phase_done;
   logic              w_req_ready;
   logic              w_accept;
   logic              w_capture;
   logic              w_enter_resp;

   logic              r_we;
   logic [7:0]        r_sram_data_in;
   logic [9:0]        r_sram_word_sel;
   logic [1:0]        r_sram_bank_sel;
   logic [1:0]        r_sram_byte_sel;
   logic              r_sram_we;
   logic              r_sram_re;
   logic              r_rsp_valid;
   logic [7:0]        r_rsp_rdata;
   logic              r_rsp_we;
   logic              r_busy;

   logic              w_sram_we_nxt;
   logic              w_sram_re_nxt;
   logic              w_rsp_valid_nxt;
   logic [7:0]        w_rsp_rdata_nxt;
   logic              w_rsp_we_nxt;
   logic              w_busy_nxt;

   assign w_req_ready = (r_state == S_IDLE) & ~rst;
   assign w_accept    = w_req_ready & req_valid;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and phase-counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_last      = SETUP_LAST;
      case (r_state)
         S_SETUP: w_last = SETUP_LAST;
         S_PULSE: w_last = PULSE_LAST;
         S_HOLD:  w_last = HOLD_LAST;
         default: w_last = SETUP_LAST;
      endcase
      w_phase_done = (r_cnt == w_last);
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_SETUP;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SETUP: begin
            if (w_phase_done) begin
               w_state_nxt = S_PULSE;
            end else begin
               w_state_nxt = S_SETUP;
            end
         end
         S_PULSE: begin
            if (w_phase_done) begin
               w_state_nxt = S_HOLD;
            end else begin
               w_state_nxt = S_PULSE;
            end
         end
         S_HOLD: begin
            if (w_phase_done) begin
               w_state_nxt = S_RESP;
            end else begin
               w_state_nxt = S_HOLD;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_RESP;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
         w_cnt_nxt = {CNT_W{1'b0}};
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   // Output decode from the upcoming state so every output comes straight from a flop.
   always_comb begin
      w_capture       = (r_state == S_PULSE) & w_phase_done;
      w_enter_resp    = (r_state == S_HOLD) & w_phase_done;
      w_sram_we_nxt   = (w_state_nxt == S_PULSE) & r_we;
      w_sram_re_nxt   = (w_state_nxt == S_PULSE) & ~r_we;
      w_rsp_valid_nxt = (w_state_nxt == S_RESP);
      w_busy_nxt      = (w_state_nxt != S_IDLE);
      if (w_capture) begin
         w_rsp_rdata_nxt = r_we ? 8'h00 : sram_data_out;
      end else begin
         w_rsp_rdata_nxt = r_rsp_rdata;
      end
      if (w_enter_resp) begin
         w_rsp_we_nxt = r_we;
      end else begin
         w_rsp_we_nxt = r_rsp_we;
      end
   end

   // Output, request-latch and phase-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt           <= {CNT_W{1'b0}};
         r_we            <= 1'b0;
         r_sram_data_in  <= 8'h00;
         r_sram_word_sel <= 10'h000;
         r_sram_bank_sel <= 2'b00;
         r_sram_byte_sel <= 2'b00;
         r_sram_we       <= 1'b0;
         r_sram_re       <= 1'b0;
         r_rsp_valid     <= 1'b0;
         r_rsp_rdata     <= 8'h00;
         r_rsp_we        <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_sram_we   <= w_sram_we_nxt;
         r_sram_re   <= w_sram_re_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_we    <= w_rsp_we_nxt;
         r_busy      <= w_busy_nxt;
         // Select/data pins only move on a new accept and hold their value while idle.
         if (w_accept) begin
            r_we            <= req_we;
            r_sram_data_in  <= req_wdata;
            r_sram_word_sel <= req_word;
            r_sram_bank_sel <= req_bank;
            r_sram_byte_sel <= req_byte;
         end
      end
   end

`ifdef IMPACT_ACCESS_CNT_EN
   logic [15:0] r_wr_count;
   logic [15:0] r_rd_count;

   // Saturating per-direction access counters, bumped on entry to RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_count <= 16'h0000;
         r_rd_count <= 16'h0000;
      end else if (w_enter_resp) begin
         if (r_we && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
         end
         if (!r_we && (r_rd_count != 16'hFFFF)) begin
            r_rd_count <= r_rd_count + 16'd1;
         end
      end
   end

   assign wr_count = r_wr_count;
   assign rd_count = r_rd_count;
`endif

   assign req_ready     = w_req_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_we        = r_rsp_we;
   assign busy          = r_busy;
   assign sram_data_in  = r_sram_data_in;
   assign sram_word_sel = r_sram_word_sel;
   assign sram_bank_sel = r_sram_bank_sel;
   assign sram_byte_sel = r_sram_byte_sel;
   assign sram_we       = r_sram_we;
   assign sram_re       = r_sram_re;

endmodule

// File: tb/tb_impact_access_sequencer.sv
// Directed bench for impact_access_sequencer: default timing instance plus a
// minimum-timing instance (SETUP_CYC=0, PULSE_CYC=1, HOLD_CYC=0).
module tb_impact_access_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, f_req_valid;
   logic        req_we;
   logic [1:0]  req_bank;
   logic [9:0]  req_word;
   logic [1:0]  req_byte;
   logic [7:0]  req_wdata;
   logic        rsp_ready, f_rsp_ready;
   logic [7:0]  sram_data_out;

   logic        req_ready, rsp_valid, rsp_we, busy, sram_we, sram_re;
   logic [7:0]  rsp_rdata, sram_data_in;
   logic [9:0]  sram_word_sel;
   logic [1:0]  sram_bank_sel, sram_byte_sel;

   logic        f_req_ready, f_rsp_valid, f_rsp_we, f_busy, f_sram_we, f_sram_re;
   logic [7:0]  f_rsp_rdata, f_sram_data_in;
   logic [9:0]  f_sram_word_sel;
   logic [1:0]  f_sram_bank_sel, f_sram_byte_sel;
`ifdef IMPACT_ACCESS_CNT_EN
   logic [15:0] wr_count, rd_count, f_wr_count, f_rd_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   impact_access_sequencer u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_bank(req_bank), .req_word(req_word), .req_byte(req_byte), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_we(rsp_we),
      .busy(busy), .sram_data_in(sram_data_in), .sram_word_sel(sram_word_sel),
      .sram_bank_sel(sram_bank_sel), .sram_byte_sel(sram_byte_sel), .sram_we(sram_we),
      .sram_re(sram_re),
`ifdef IMPACT_ACCESS_CNT_EN
      .wr_count(wr_count), .rd_count(rd_count),
`endif
      .sram_data_out(sram_data_out)
   );

   impact_access_sequencer #(.SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0), .CNT_W(4)) u_fast (
      .clk(clk), .rst(rst), .req_valid(f_req_valid), .req_ready(f_req_ready), .req_we(req_we),
      .req_bank(req_bank), .req_word(req_word), .req_byte(req_byte), .req_wdata(req_wdata),
      .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_rdata(f_rsp_rdata),
      .rsp_we(f_rsp_we), .busy(f_busy), .sram_data_in(f_sram_data_in),
      .sram_word_sel(f_sram_word_sel), .sram_bank_sel(f_sram_bank_sel),
      .sram_byte_sel(f_sram_byte_sel), .sram_we(f_sram_we), .sram_re(f_sram_re),
`ifdef IMPACT_ACCESS_CNT_EN
      .wr_count(f_wr_count), .rd_count(f_rd_count),
`endif
      .sram_data_out(sram_data_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_sel(input string tag, input logic [9:0] w, input logic [1:0] b,
                            input logic [1:0] y, input logic [7:0] d);
      check({tag, "_word"}, {22'd0, sram_word_sel}, {22'd0, w});
      check({tag, "_bank"}, {30'd0, sram_bank_sel}, {30'd0, b});
      check({tag, "_byte"}, {30'd0, sram_byte_sel}, {30'd0, y});
      check({tag, "_data"}, {24'd0, sram_data_in},  {24'd0, d});
   endtask

`ifdef IMPACT_ACCESS_CNT_EN
   task automatic run_access(input logic we);
      int n;
      req_we = we; req_bank = 2'd1; req_word = 10'h021; req_byte = 2'd0; req_wdata = 8'h11;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      check("acc_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; f_req_valid = 1'b0; rsp_ready = 1'b0; f_rsp_ready = 1'b0;
      req_we = 1'b0; req_bank = 2'd0; req_word = 10'h000; req_byte = 2'd0; req_wdata = 8'h00;
      sram_data_out = 8'hFF;
      repeat (3) tick();

      // Reset state
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_sram_we",   {31'd0, sram_we},   32'd0);
      check("rst_sram_re",   {31'd0, sram_re},   32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
      check("rst_rsp_we",    {31'd0, rsp_we},    32'd0);
      check_sel("rst_sel", 10'h000, 2'd0, 2'd0, 8'h00);
      rst = 1'b0;
      #1;
      check("idle_req_ready", {31'd0, req_ready}, 32'd1);

      // Write: bank 2, word 155, byte 3, data A5
      req_we = 1'b1; req_bank = 2'd2; req_word = 10'h155; req_byte = 2'd3; req_wdata = 8'hA5;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c <= 7) check_sel($sformatf("wr_c%0d", c), 10'h155, 2'd2, 2'd3, 8'hA5);
         check($sformatf("wr_we_c%0d", c), {31'd0, sram_we}, {31'd0, (c >= 3 && c <= 6)});
         check($sformatf("wr_re_c%0d", c), {31'd0, sram_re}, 32'd0);
         check($sformatf("wr_rv_c%0d", c), {31'd0, rsp_valid}, {31'd0, (c == 8)});
         check($sformatf("wr_rdy_c%0d", c), {31'd0, req_ready}, 32'd0);
         if (c < 8) tick();
      end
      check("wr_rsp_we",    {31'd0, rsp_we},    32'd1);
      check("wr_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("wr_done_rv",   {31'd0, rsp_valid}, 32'd0);
      check("wr_done_busy", {31'd0, busy},      32'd0);
      check("wr_done_rdy",  {31'd0, req_ready}, 32'd1);
      check_sel("wr_idle_keep", 10'h155, 2'd2, 2'd3, 8'hA5);
      check("fast_untouched", {31'd0, f_busy}, 32'd0);

      // Read: bank 0, word 3FF, byte 1; head returns 3C only in cycle 6
      req_we = 1'b0; req_bank = 2'd0; req_word = 10'h3FF; req_byte = 2'd1; req_wdata = 8'h00;
      req_valid = 1'b1;
      tick();
      // Second request held on the bus for the whole read; it must be ignored
      req_we = 1'b1; req_bank = 2'd1; req_word = 10'h0AA; req_byte = 2'd2; req_wdata = 8'h5A;
      for (int c = 1; c <= 8; c++) begin
         sram_data_out = (c == 6) ? 8'h3C : 8'hFF;
         if (c <= 7) check_sel($sformatf("rd_c%0d", c), 10'h3FF, 2'd0, 2'd1, 8'h00);
         check($sformatf("rd_re_c%0d", c), {31'd0, sram_re}, {31'd0, (c >= 3 && c <= 6)});
         check($sformatf("rd_we_c%0d", c), {31'd0, sram_we}, 32'd0);
         check($sformatf("rd_rv_c%0d", c), {31'd0, rsp_valid}, {31'd0, (c == 8)});
         if (c < 8) tick();
      end
      for (int k = 0; k < 5; k++) begin
         check($sformatf("stall_rv_%0d", k),    {31'd0, rsp_valid}, 32'd1);
         check($sformatf("stall_rdata_%0d", k), {24'd0, rsp_rdata}, 32'h3C);
         check($sformatf("stall_we_%0d", k),    {31'd0, rsp_we},    32'd0);
         check($sformatf("stall_rdy_%0d", k),   {31'd0, req_ready}, 32'd0);
         if (k < 4) tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rd_done_rv",  {31'd0, rsp_valid}, 32'd0);
      check("rd_done_rdy", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      check_sel("req2_c1", 10'h0AA, 2'd1, 2'd2, 8'h5A);
      check("req2_busy", {31'd0, busy}, 32'd1);
      repeat (7) tick();
      check("req2_rv",    {31'd0, rsp_valid}, 32'd1);
      check("req2_rspwe", {31'd0, rsp_we},    32'd1);
      check("req2_rdata", {24'd0, rsp_rdata}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("req2_done_rv", {31'd0, rsp_valid}, 32'd0);

      // Reset in cycle 4 of a write
      req_we = 1'b1; req_bank = 2'd3; req_word = 10'h2AB; req_byte = 2'd0; req_wdata = 8'hC3;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (3) tick();
      check("mid_we_c4", {31'd0, sram_we}, 32'd1);
      rst = 1'b1;
      tick();
      check("mid_we_c5",   {31'd0, sram_we},   32'd0);
      check("mid_busy_c5", {31'd0, busy},      32'd0);
      check("mid_rv_c5",   {31'd0, rsp_valid}, 32'd0);
      check_sel("mid_sel_c5", 10'h000, 2'd0, 2'd0, 8'h00);
      rst = 1'b0;
      tick();
      check("mid_rdy_after", {31'd0, req_ready}, 32'd1);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("mid_norsp_%0d", k), {31'd0, rsp_valid}, 32'd0);
         tick();
      end

      // Minimum-timing instance: read, enable in cycle 2, response in cycle 4
      req_we = 1'b0; req_bank = 2'd1; req_word = 10'h012; req_byte = 2'd2; req_wdata = 8'h00;
      f_req_valid = 1'b1;
      tick();
      f_req_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         sram_data_out = (c == 2) ? 8'h77 : 8'h11;
         check($sformatf("f_re_c%0d", c), {31'd0, f_sram_re}, {31'd0, (c == 2)});
         check($sformatf("f_we_c%0d", c), {31'd0, f_sram_we}, 32'd0);
         check($sformatf("f_rv_c%0d", c), {31'd0, f_rsp_valid}, {31'd0, (c == 4)});
         if (c < 4) tick();
      end
      check("f_rdata", {24'd0, f_rsp_rdata}, 32'h77);
      check("f_rspwe", {31'd0, f_rsp_we},    32'd0);
      f_rsp_ready = 1'b1;
      tick();
      f_rsp_ready = 1'b0;
      check("f_done_rv", {31'd0, f_rsp_valid}, 32'd0);

`ifdef IMPACT_ACCESS_CNT_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run_access(1'b1);
      run_access(1'b1);
      run_access(1'b1);
      run_access(1'b0);
      run_access(1'b0);
      check("wr_count", {16'd0, wr_count}, 32'd3);
      check("rd_count", {16'd0, rd_count}, 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("wr_count_clr", {16'd0, wr_count}, 32'd0);
      check("rd_count_clr", {16'd0, rd_count}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
